// File: rtl/noc_pkg.sv
// Shared router sizing plus the credit/lock types used by the switch allocator.
package noc_pkg;

  localparam int PORT_NUM    = 5;
  localparam int VC_NUM      = 2;
  localparam int PORT_SIZE   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CREDIT_MAX  = 4;
  localparam int CREDIT_SIZE = $clog2(CREDIT_MAX + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic [PORT_SIZE-1:0] port;
    logic [VC_SIZE-1:0]   vc;
  } lock_owner_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search at a
// stored pointer; the pointer moves past the winner when update_en is high.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_nxt;
  int               best;

  // Rank each requester by its distance from the pointer; the nearest wins.
  always_comb begin
    best    = N;
    grant   = '0;
    ptr_nxt = ptr_q;
    for (int j = 0; j < N; j++) begin
      if (request[j] && (((j - int'(ptr_q)) + N) % N) < best)
        best = ((j - int'(ptr_q)) + N) % N;
    end
    for (int j = 0; j < N; j++) begin
      if (request[j] && (((j - int'(ptr_q)) + N) % N) == best) begin
        grant[j] = 1'b1;
        ptr_nxt  = PTR_W'((j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else if (update_en && |request)
      ptr_q <= ptr_nxt;
  end

endmodule

// File: rtl/credit_switch_allocator.sv
// Separable input-first switch allocator with per-downstream-VC credits and an
// optional wormhole lock that holds an output from head flit to tail flit.
module credit_switch_allocator
  import noc_pkg::*;
#(
  parameter int LOCK_PACKETS = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                switch_request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                tail_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                credit_return_i,
  output logic [PORT_NUM-1:0]                            valid_sel_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]             input_vc_sel_o,
  output logic [PORT_NUM-1:0]                            valid_flit_o,
  output logic                                           credit_err_o
);

  logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_SIZE-1:0] credit_q;
  lock_state_t [PORT_NUM-1:0]                       lock_state_q;
  lock_owner_t [PORT_NUM-1:0]                       lock_owner_q;
  logic                                             credit_err_q;

  logic [PORT_NUM-1:0][VC_NUM-1:0]    eligible, forced, in_req, in_gnt, credit_dec;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   sel_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel_out;
  logic [PORT_NUM-1:0]                in_valid, in_win, out_valid, grant_tail;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_req, out_gnt;
  lock_owner_t [PORT_NUM-1:0]         grant_owner;
  logic                               own;

  // Eligibility: credit available and the target output not held by someone else.
  always_comb begin
    eligible = '0;
    forced   = '0;
    in_req   = '0;
    own      = 1'b0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (switch_request_i[p][v] && int'(out_port_i[p][v]) < PORT_NUM) begin
          own = (LOCK_PACKETS != 0) && (lock_state_q[out_port_i[p][v]] == LOCKED) &&
                (lock_owner_q[out_port_i[p][v]].port == PORT_SIZE'(p)) &&
                (lock_owner_q[out_port_i[p][v]].vc == VC_SIZE'(v));
          eligible[p][v] = (credit_q[out_port_i[p][v]][downstream_vc_i[p][v]] != '0) &&
                           (own || (LOCK_PACKETS == 0) ||
                            (lock_state_q[out_port_i[p][v]] == IDLE));
          forced[p][v]   = eligible[p][v] && own;
        end
      end
      in_req[p] = (|forced[p]) ? forced[p] : eligible[p];
    end
  end

  for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_in_arb
    rr_arbiter #(.N(VC_NUM)) u_in_arb (
      .clk       (clk),
      .rst       (rst),
      .request   (in_req[gp]),
      .update_en (in_win[gp]),
      .grant     (in_gnt[gp])
    );
  end

  always_comb begin
    in_valid = '0;
    sel_vc   = '0;
    sel_out  = '0;
    out_req  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      in_valid[p] = |in_gnt[p];
      for (int v = 0; v < VC_NUM; v++) begin
        if (in_gnt[p][v]) begin
          sel_vc[p]  = VC_SIZE'(v);
          sel_out[p] = out_port_i[p][v];
        end
      end
    end
    for (int o = 0; o < PORT_NUM; o++)
      for (int p = 0; p < PORT_NUM; p++)
        out_req[o][p] = in_valid[p] && (sel_out[p] == PORT_SIZE'(o));
  end

  for (genvar go = 0; go < PORT_NUM; go++) begin : g_out_arb
    rr_arbiter #(.N(PORT_NUM)) u_out_arb (
      .clk       (clk),
      .rst       (rst),
      .request   (out_req[go]),
      .update_en (out_valid[go]),
      .grant     (out_gnt[go])
    );
  end

  // Final grants: an input winner that loses here keeps its VC pointer.
  always_comb begin
    in_win      = '0;
    out_valid   = '0;
    grant_tail  = '0;
    grant_owner = '0;
    credit_dec  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (out_gnt[o][p]) begin
          out_valid[o]        = 1'b1;
          in_win[p]           = 1'b1;
          grant_owner[o].port = PORT_SIZE'(p);
          grant_owner[o].vc   = sel_vc[p];
          grant_tail[o]       = tail_i[p][sel_vc[p]];
          credit_dec[o][downstream_vc_i[p][sel_vc[p]]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_sel_o    = '0;
    vc_sel_o       = '0;
    input_vc_sel_o = '0;
    valid_flit_o   = '0;
    if (!rst) begin
      valid_sel_o  = in_win;
      valid_flit_o = out_valid;
      for (int p = 0; p < PORT_NUM; p++)
        if (in_win[p]) vc_sel_o[p] = sel_vc[p];
      for (int o = 0; o < PORT_NUM; o++)
        if (out_valid[o]) input_vc_sel_o[o] = grant_owner[o].port;
    end
  end

  assign credit_err_o = credit_err_q;

  // A grant and a return on the same counter cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_err_q <= 1'b0;
      for (int o = 0; o < PORT_NUM; o++)
        for (int d = 0; d < VC_NUM; d++)
          credit_q[o][d] <= CREDIT_SIZE'(CREDIT_MAX);
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int d = 0; d < VC_NUM; d++) begin
          if (credit_dec[o][d] && !credit_return_i[o][d])
            credit_q[o][d] <= credit_q[o][d] - CREDIT_SIZE'(1);
          else if (!credit_dec[o][d] && credit_return_i[o][d]) begin
            if (credit_q[o][d] == CREDIT_SIZE'(CREDIT_MAX))
              credit_err_q <= 1'b1;
            else
              credit_q[o][d] <= credit_q[o][d] + CREDIT_SIZE'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state_q <= {PORT_NUM{IDLE}};
    end else if (LOCK_PACKETS != 0) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        if (out_valid[o] && lock_state_q[o] == IDLE && !grant_tail[o])
          lock_state_q[o] <= LOCKED;
        else if (out_valid[o] && lock_state_q[o] == LOCKED && grant_tail[o])
          lock_state_q[o] <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < PORT_NUM; o++)
      if (out_valid[o] && lock_state_q[o] == IDLE && !grant_tail[o])
        lock_owner_q[o] <= grant_owner[o];
  end

endmodule

// File: tb/tb_credit_switch_allocator.sv
// Bench for credit_switch_allocator: directed scenarios plus random traffic
// checked every cycle against an array-based model of the allocation rules.
module tb_credit_switch_allocator;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                req, tail, cret;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] oport;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   dvc;
  logic [PORT_NUM-1:0]                            valid_sel, vflit;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]             isel;
  logic                                           cerr;

  credit_switch_allocator #(.LOCK_PACKETS(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .switch_request_i (req),
    .out_port_i       (oport),
    .downstream_vc_i  (dvc),
    .tail_i           (tail),
    .credit_return_i  (cret),
    .valid_sel_o      (valid_sel),
    .vc_sel_o         (vc_sel),
    .input_vc_sel_o   (isel),
    .valid_flit_o     (vflit),
    .credit_err_o     (cerr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: plain integers per output/VC.
  int m_cr [PORT_NUM][VC_NUM];
  int m_ip [PORT_NUM];
  int m_op [PORT_NUM];
  bit m_lk [PORT_NUM];
  int m_lp [PORT_NUM];
  int m_lv [PORT_NUM];
  bit m_err;
  int g_src [PORT_NUM];
  int g_vc  [PORT_NUM];

  function automatic void model_reset();
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int d = 0; d < VC_NUM; d++) m_cr[o][d] = CREDIT_MAX;
      m_ip[o] = 0; m_op[o] = 0; m_lk[o] = 0; m_lp[o] = 0; m_lv[o] = 0;
    end
    m_err = 0;
  endfunction

  function automatic void model_eval();
    int pick [PORT_NUM];
    bit el [VC_NUM];
    bit fo [VC_NUM];
    bit anyf, own;
    int o, d, v, p;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      pick[ip] = -1;
      anyf = 0;
      for (int iv = 0; iv < VC_NUM; iv++) begin
        o = int'(oport[ip][iv]);
        d = int'(dvc[ip][iv]);
        el[iv] = 0;
        fo[iv] = 0;
        if (req[ip][iv] && o < PORT_NUM) begin
          own = m_lk[o] && m_lp[o] == ip && m_lv[o] == iv;
          el[iv] = (m_cr[o][d] > 0) && (!m_lk[o] || own);
          fo[iv] = el[iv] && own;
        end
        anyf |= fo[iv];
      end
      for (int k = 0; k < VC_NUM; k++) begin
        v = (m_ip[ip] + k) % VC_NUM;
        if (pick[ip] < 0 && (anyf ? fo[v] : el[v])) pick[ip] = v;
      end
    end
    for (int io = 0; io < PORT_NUM; io++) begin
      g_src[io] = -1;
      g_vc[io]  = -1;
      for (int k = 0; k < PORT_NUM; k++) begin
        p = (m_op[io] + k) % PORT_NUM;
        if (g_src[io] < 0 && pick[p] >= 0 && int'(oport[p][pick[p]]) == io) begin
          g_src[io] = p;
          g_vc[io]  = pick[p];
        end
      end
    end
  endfunction

  function automatic void model_commit();
    bit dec [PORT_NUM][VC_NUM];
    int p, v;
    for (int o = 0; o < PORT_NUM; o++)
      for (int d = 0; d < VC_NUM; d++) dec[o][d] = 0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (g_src[o] >= 0) begin
        p = g_src[o];
        v = g_vc[o];
        m_ip[p] = (v + 1) % VC_NUM;
        m_op[o] = (p + 1) % PORT_NUM;
        dec[o][int'(dvc[p][v])] = 1;
        if (!m_lk[o] && !tail[p][v]) begin
          m_lk[o] = 1; m_lp[o] = p; m_lv[o] = v;
        end else if (m_lk[o] && tail[p][v]) begin
          m_lk[o] = 0;
        end
      end
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int d = 0; d < VC_NUM; d++) begin
        if (dec[o][d] && !cret[o][d]) m_cr[o][d]--;
        else if (!dec[o][d] && cret[o][d]) begin
          if (m_cr[o][d] == CREDIT_MAX) m_err = 1;
          else m_cr[o][d]++;
        end
      end
    end
  endfunction

  logic [PORT_NUM-1:0]                e_vs, e_vf;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   e_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] e_is;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      model_reset();
      check("rst_valid_sel", 64'(valid_sel), 64'(0));
      check("rst_vc_sel", 64'(vc_sel), 64'(0));
      check("rst_input_sel", 64'(isel), 64'(0));
      check("rst_valid_flit", 64'(vflit), 64'(0));
      check("rst_credit_err", 64'(cerr), 64'(0));
    end else begin
      model_eval();
      e_vs = '0; e_vf = '0; e_vc = '0; e_is = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
        if (g_src[o] >= 0) begin
          e_vf[o]        = 1'b1;
          e_is[o]        = PORT_SIZE'(g_src[o]);
          e_vs[g_src[o]] = 1'b1;
          e_vc[g_src[o]] = VC_SIZE'(g_vc[o]);
        end
      end
      check("valid_sel", 64'(valid_sel), 64'(e_vs));
      check("vc_sel", 64'(vc_sel), 64'(e_vc));
      check("input_vc_sel", 64'(isel), 64'(e_is));
      check("valid_flit", 64'(vflit), 64'(e_vf));
      check("credit_err", 64'(cerr), 64'(m_err));
      model_commit();
    end
  end

  logic [PORT_NUM-1:0]                s_vf, s_vs;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] s_is;
  logic                               s_err;
  logic [5:0]                         seq;

  task automatic clear_in();
    req = '0; tail = '0; cret = '0; oport = '0; dvc = '0;
  endtask

  // Inputs change only just after a rising edge; outputs are sampled mid-cycle.
  task automatic cyc();
    @(negedge clk);
    #2;
    s_vf = vflit; s_vs = valid_sel; s_is = isel; s_err = cerr;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  int fair_exp [6] = '{0, 1, 3, 0, 1, 3};
  int lk_req   [5] = '{1, 0, 1, 1, 0};
  int lk_tail  [5] = '{0, 0, 0, 1, 0};
  int lk_is    [5] = '{1, 0, 1, 1, 2};
  int lk_vf    [5] = '{1, 0, 1, 1, 1};

  initial begin
    clear_in();
    do_reset();

    // Credit exhaustion on output 2 / DVC 0.
    req[0][0] = 1; oport[0][0] = 3'd2; dvc[0][0] = 0; tail[0][0] = 1;
    seq = '0;
    for (int i = 0; i < 6; i++) begin cyc(); seq[i] = s_vf[2]; end
    check("exhaust_seq", 64'(seq), 64'(6'b001111));

    // Refill to 1, then grant with simultaneous return keeps the credit at 1.
    req[0][0] = 0; cret[2][0] = 1;
    cyc();
    req[0][0] = 1;
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) cret[2][0] = 0;
      cyc();
      seq[i] = s_vf[2];
    end
    check("grant_return_seq", 64'(seq), 64'(6'b011111));

    // Output-port round robin among inputs 0, 1, 3.
    do_reset();
    for (int p = 0; p < PORT_NUM; p++) begin
      if (p == 0 || p == 1 || p == 3) begin
        req[p][0] = 1; oport[p][0] = 3'd4; tail[p][0] = 1;
      end
    end
    cret[4][0] = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("fair_src", 64'(s_is[4]), 64'(fair_exp[i]));
    end

    // Wormhole lock: input 1 VC1 holds output 0 until its tail.
    do_reset();
    oport[1][1] = 3'd0; dvc[1][1] = 1;
    req[2][0] = 1; oport[2][0] = 3'd0; dvc[2][0] = 0; tail[2][0] = 1;
    for (int i = 0; i < 5; i++) begin
      req[1][1]  = 1'(lk_req[i]);
      tail[1][1] = 1'(lk_tail[i]);
      cyc();
      check("lock_src", 64'(s_is[0]), 64'(lk_is[i]));
      check("lock_vf", 64'(s_vf[0]), 64'(lk_vf[i]));
    end

    // Overflow: return at full credit is sticky and does not grow the counter.
    do_reset();
    cret[3][0] = 1;
    cyc();
    check("ovf_err_same_cycle", 64'(s_err), 64'(0));
    cret[3][0] = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ovf_err_sticky", 64'(s_err), 64'(1));
    end
    req[0][0] = 1; oport[0][0] = 3'd3; dvc[0][0] = 0; tail[0][0] = 1;
    seq = '0;
    for (int i = 0; i < 6; i++) begin cyc(); seq[i] = s_vf[3]; end
    check("ovf_credit_seq", 64'(seq), 64'(6'b001111));

    // Reset in the middle of a locked packet.
    do_reset();
    req[0][0] = 1; oport[0][0] = 3'd0; dvc[0][0] = 0; tail[0][0] = 0;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    check("rst_async_vf", 64'(vflit), 64'(0));
    check("rst_async_vs", 64'(valid_sel), 64'(0));
    req[0][0] = 0;
    req[3][0] = 1; oport[3][0] = 3'd0; dvc[3][0] = 0; tail[3][0] = 1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    seq = '0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      seq[i] = s_vf[0];
      if (i == 0) check("post_rst_src", 64'(s_is[0]), 64'(3));
    end
    check("post_rst_credit_seq", 64'(seq), 64'(6'b001111));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          req[p][v]   = ($urandom_range(0, 99) < 60);
          oport[p][v] = PORT_SIZE'($urandom_range(0, PORT_NUM - 1));
          dvc[p][v]   = VC_SIZE'($urandom_range(0, VC_NUM - 1));
          tail[p][v]  = ($urandom_range(0, 99) < 50);
          cret[p][v]  = ($urandom_range(0, 99) < 15);
        end
      end
      cyc();
    end

    clear_in();
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
